// File: rtl/std_cache_pkg.sv
// Shared D-cache definitions: geometry defaults, flush FSM states and the
// per-way valid/dirty record stored in the tag-status array.
package std_cache_pkg;

    localparam int unsigned DCACHE_NUM_WORDS = 256;
    localparam int unsigned DCACHE_SET_ASSOC = 8;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        READ,
        EVAL,
        WB,
        INVAL,
        DONE
    } flush_state_e;

    typedef struct packed {
        logic valid;
        logic dirty;
    } vld_dirty_t;

endpackage

// File: rtl/dcache_flush_ctrl_if.sv
// Signal bundle around the flush controller: flush handshake, valid/dirty
// array port and the write-back channel towards the miss handler.
interface dcache_flush_ctrl_if
    import std_cache_pkg::*;
#(
    parameter int unsigned NumSets = DCACHE_NUM_WORDS,
    parameter int unsigned NumWays = DCACHE_SET_ASSOC
);
    localparam int unsigned IdxW = $clog2(NumSets);
    localparam int unsigned WayW = (NumWays > 1) ? $clog2(NumWays) : 1;

    logic                flush;
    logic                flush_ack;
    logic                busy;
    logic [NumWays-1:0]  req;
    logic [IdxW-1:0]     addr;
    logic                gnt;
    logic                we;
    logic [NumWays-1:0]  vld_be;
    logic [NumWays-1:0]  vld;
    logic [NumWays-1:0]  dirty;
    logic                wb_valid;
    logic                wb_ready;
    logic [IdxW-1:0]     wb_idx;
    logic [WayW-1:0]     wb_way;

    modport master (
        input  flush, gnt, vld, dirty, wb_ready,
        output flush_ack, busy, req, addr, we, vld_be, wb_valid, wb_idx, wb_way
    );

    modport slave (
        output flush, gnt, vld, dirty, wb_ready,
        input  flush_ack, busy, req, addr, we, vld_be, wb_valid, wb_idx, wb_way
    );

endinterface

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros (index of the
// lowest set bit), MODE=1 counts leading zeros. empty_o flags an all-zero input.
module lzc #(
    parameter int unsigned WIDTH = 2,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CntW-1:0]  cnt_o,
    output logic             empty_o
);

    always_comb begin
        cnt_o = '0;
        // Last match wins: the scan order picks the bit nearest the counted end.
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE) begin
                if (in_i[i]) cnt_o = CntW'(WIDTH - 1 - i);
            end else if (in_i[WIDTH-1-i]) begin
                cnt_o = CntW'(WIDTH - 1 - i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/dcache_flush_ctrl.sv
// D-cache flush controller: clears the valid/dirty array after reset, and on a
// flush walks every set, hands dirty lines to the miss handler, then invalidates.
module dcache_flush_ctrl
    import std_cache_pkg::*;
#(
    parameter int unsigned NumSets = DCACHE_NUM_WORDS,
    parameter int unsigned NumWays = DCACHE_SET_ASSOC,
    localparam int unsigned IdxW = $clog2(NumSets),
    localparam int unsigned WayW = (NumWays > 1) ? $clog2(NumWays) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    output logic               flush_ack_o,
    output logic               busy_o,
    output logic [NumWays-1:0] req_o,
    output logic [IdxW-1:0]    addr_o,
    input  logic               gnt_i,
    output logic               we_o,
    output logic [NumWays-1:0] vld_be_o,
    input  logic [NumWays-1:0] vld_i,
    input  logic [NumWays-1:0] dirty_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [IdxW-1:0]    wb_idx_o,
    output logic [WayW-1:0]    wb_way_o
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);

    flush_state_e       state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [NumWays-1:0] pending_q, pending_d;
    logic               eval_q, eval_d;

    vld_dirty_t [NumWays-1:0] rd_line;
    logic [NumWays-1:0]       rd_pending;
    logic [NumWays-1:0]       pending_rest;
    logic                     sram_req;
    logic                     accept;
    logic                     pending_empty;
    logic [WayW-1:0]          wb_way;

    always_comb begin
        for (int w = 0; w < NumWays; w++) begin
            rd_line[w].valid = vld_i[w];
            rd_line[w].dirty = dirty_i[w];
            rd_pending[w]    = rd_line[w].valid & rd_line[w].dirty;
        end
    end

    lzc #(
        .WIDTH (NumWays),
        .MODE  (1'b0)
    ) i_way_sel (
        .in_i    (pending_q),
        .cnt_o   (wb_way),
        .empty_o (pending_empty)
    );

    // Dropping the lowest set bit matches the way the counter is selecting.
    assign pending_rest = pending_q & (pending_q - NumWays'(1));
    assign accept       = sram_req & gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INIT;
            idx_q     <= '0;
            pending_q <= '0;
            eval_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            eval_q    <= eval_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        eval_d    = (state_q == EVAL);
        unique case (state_q)
            INIT: begin
                if (accept) begin
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) state_d = IDLE;
                end
            end
            IDLE:  if (flush_i) state_d = READ;
            READ:  if (accept) state_d = EVAL;
            EVAL: begin
                pending_d = rd_pending;
                state_d   = (|rd_pending) ? WB : INVAL;
            end
            WB: begin
                if (wb_ready_i) begin
                    pending_d = pending_rest;
                    if (pending_rest == '0) state_d = INVAL;
                end
            end
            INVAL: begin
                if (accept) begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = (idx_q == LastIdx) ? DONE : READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // The first INVAL cycle straight after EVAL stays quiet so the read
    // response and the invalidate write never share adjacent array cycles.
    always_comb begin
        sram_req    = rst_ni && ((state_q == INIT) || (state_q == READ) ||
                                 ((state_q == INVAL) && !eval_q));
        we_o        = sram_req && (state_q != READ);
        req_o       = {NumWays{sram_req}};
        vld_be_o    = {NumWays{we_o}};
        addr_o      = idx_q;
        busy_o      = (state_q != IDLE);
        flush_ack_o = (state_q == DONE);
        wb_valid_o  = (state_q == WB) && !pending_empty;
        wb_idx_o    = idx_q;
        wb_way_o    = wb_way;
    end

endmodule

// File: doc/dcache_flush_ctrl.md
DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

Interface
REQ-001 SHALL have parameter NumSets, default 256, meaning number of cache sets (power of two, >=2).
REQ-002 SHALL have parameter NumWays, default 8, meaning set associativity (>=1).
REQ-003 SHALL define IdxW = $clog2(NumSets) locally.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1, flush request, held high until acknowledged.
REQ-007 SHALL have port flush_ack_o, output, 1, single-cycle flush completion pulse.
REQ-008 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port req_o, output, NumWays, per-way SRAM request to the tag/valid-dirty arbiter.
REQ-010 SHALL have port addr_o, output, IdxW, set index of the current request.
REQ-011 SHALL have port gnt_i, input, 1, arbiter grant; the request is accepted in a cycle where any req_o bit and gnt_i are both high.
REQ-012 SHALL have port we_o, output, 1, write enable for the valid/dirty array.
REQ-013 SHALL have port vld_be_o, output, NumWays, per-way valid/dirty byte-enable.
REQ-014 SHALL have port vld_i, input, NumWays, per-way valid bits read back from the array.
REQ-015 SHALL have port dirty_i, input, NumWays, per-way dirty bits read back from the array.
REQ-016 SHALL have port wb_valid_o, output, 1, write-back request to the miss handler.
REQ-017 SHALL have port wb_ready_i, input, 1, write-back accepted.
REQ-018 SHALL have port wb_idx_o, output, IdxW, set index of the line to write back.
REQ-019 SHALL have port wb_way_o, output, $clog2(NumWays) (min 1), way of the line to write back.

Function
REQ-020 SHALL implement the states INIT, IDLE, READ, EVAL, WB, INVAL, DONE.
REQ-021 SHALL leave reset in INIT with set index 0.
REQ-022 INIT SHALL drive all req_o bits high, we_o=1, vld_be_o all ones (writes valid=0, dirty=0) and, on each grant, increment the set index.
REQ-023 INIT SHALL go to IDLE on the grant at index NumSets-1, with the index wrapping to 0, and SHALL NOT pulse flush_ack_o.
REQ-024 IDLE SHALL move to READ when flush_i=1; a flush_i asserted during INIT SHALL be served only after INIT finishes.
REQ-025 READ SHALL drive all req_o bits high with we_o=0 at the current index, holding these values until granted, and SHALL move to EVAL on grant.
REQ-026 EVAL SHALL capture pending = vld_i & dirty_i, which is valid exactly one cycle after the grant.
REQ-027 EVAL SHALL go to WB if pending is nonzero, otherwise to INVAL.
REQ-028 WB SHALL assert wb_valid_o with the lowest set bit of pending on wb_way_o and the current index on wb_idx_o.
REQ-029 WB outputs SHALL stay stable until wb_ready_i is high.
REQ-030 On a WB handshake the block SHALL clear that bit of pending and go to INVAL when no bits remain.
REQ-031 INVAL SHALL write valid=0, dirty=0 to all ways exactly as INIT does, holding until granted.
REQ-032 On an INVAL grant the block SHALL go to DONE if the index is NumSets-1 (index wraps to 0), otherwise increment the index and go to READ.
REQ-033 DONE SHALL assert flush_ack_o for exactly one cycle and then go to IDLE.
REQ-034 Deassertion of flush_i mid-sweep SHALL be ignored, and the sweep SHALL complete.
REQ-035 A request SHALL NOT be issued in the cycle directly after the EVAL capture (no read/write overlap).

Reset
REQ-036 Asynchronous assertion of rst_ni SHALL force state INIT, index 0, pending 0, and deassert flush_ack_o, wb_valid_o and we_o.
REQ-037 After reset, req_o SHALL be all ones only in INIT.
REQ-038 Reset mid-flush SHALL abandon the flush without an ack; the subsequent INIT sweep restores a clean array.

Structure
REQ-039 The state enum and the vld_dirty types SHALL live in std_cache_pkg.
REQ-040 NumSets and NumWays SHALL be driven from DCACHE_NUM_WORDS and DCACHE_SET_ASSOC.
REQ-041 The lowest-set-bit selection SHALL use the shared lzc leading/trailing-zero counter sub-module; no other sub-modules are used.

Verification
REQ-042 Reset release with NumSets=4 and gnt_i tied high -> 4 INIT writes at addr 0..3, busy_o low in cycle 5, no flush_ack_o.
REQ-043 Flush with all lines clean, gnt_i=1 -> READ/EVAL/INVAL per set, no wb_valid_o, flush_ack_o one cycle after the final INVAL grant.
REQ-044 Set 2 with vld=dirty=0b0101 and wb_ready_i delayed 3 cycles -> write-backs to way 0 then way 2 at idx 2 with stable outputs, then INVAL of set 2.
REQ-045 gnt_i low for 5 cycles during READ -> addr_o and req_o held; EVAL occurs only one cycle after the grant.
REQ-046 flush_i asserted during INIT -> flush starts after INIT completes; exactly one flush_ack_o.
REQ-047 rst_ni asserted while in WB -> wb_valid_o drops immediately, INIT restarts at index 0, and no flush_ack_o is produced.
